// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter that shares one mul_acc unit among N_REQ requesters.
// A locked owner keeps the unit, and its accumulator, across a multi-op sequence.
// If the locked owner stays idle for HOLD_TIMEOUT cycles, the unit is released.
// Ports:
//   clk, rstn              clock and async active-low reset
//   req/lock/clr/a_sb      per-requester request and per-op control bits
//   a, b                   per-requester operands, WIDTH-bit slice i for requester i
//   ack, done              one-hot 1-cycle pulses: op accepted / op finished
//   s_out                  accumulator result, updated with done
//   owner_vld, owner_id    ownership status and current/last owner
//   err                    sticky: mac_ov seen while no op was in flight
//   mac_*                  connection to the mul_acc unit
module mac_arbiter #(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned HOLD_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ-1:0]           clr,
  input  logic [N_REQ-1:0]           a_sb,
  input  logic [N_REQ*WIDTH-1:0]     a,
  input  logic [N_REQ*WIDTH-1:0]     b,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           done,
  output logic [WIDTH-1:0]           s_out,
  output logic                       owner_vld,
  output logic [$clog2(N_REQ)-1:0]   owner_id,
  output logic                       err,
  output logic                       mac_iv,
  output logic                       mac_clr,
  output logic                       mac_a_sb,
  output logic [WIDTH-1:0]           mac_a,
  output logic [WIDTH-1:0]           mac_b,
  input  logic                       mac_ov,
  input  logic [WIDTH-1:0]           mac_s
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic            lock_r;
  logic [CW-1:0]   hold_cnt;

  logic            pick_vld;
  logic [IW-1:0]   pick_id;
  logic [IW-1:0]   sel_id;
  logic            take;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  int unsigned     idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  // Round-robin pick: the first request found when scanning from last+1 upward, modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (32'(last) + 32'(k)) % N_REQ;
      if (!pick_vld && req[IW'(idx)]) begin
        pick_vld = 1'b1;
        pick_id  = IW'(idx);
      end
    end
  end

  // In HOLD, only the locked owner can be accepted.
  always_comb begin
    sel_id = (state == S_HOLD) ? owner_id : pick_id;
    take   = ((state == S_IDLE) && pick_vld) || ((state == S_HOLD) && req[owner_id]);
  end

  // Select the operands of the requester being accepted.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (sel_id == IW'(k)) begin
        sel_a = a[k*WIDTH +: WIDTH];
        sel_b = b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Arbiter FSM; all outputs are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      last      <= IW'(N_REQ - 1);
      lock_r    <= 1'b0;
      hold_cnt  <= '0;
      ack       <= '0;
      done      <= '0;
      s_out     <= '0;
      owner_vld <= 1'b0;
      owner_id  <= '0;
      err       <= 1'b0;
      mac_iv    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a_sb  <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
    end else begin
      ack     <= '0;
      done    <= '0;
      mac_iv  <= 1'b0;
      mac_clr <= 1'b0;
      if (mac_ov && (state != S_WAIT)) err <= 1'b1;
      case (state)
        S_IDLE, S_HOLD: begin
          if (take) begin
            owner_id  <= sel_id;
            owner_vld <= 1'b1;
            mac_a     <= sel_a;
            mac_b     <= sel_b;
            mac_a_sb  <= a_sb[sel_id];
            mac_clr   <= clr[sel_id];
            lock_r    <= lock[sel_id];
            ack       <= onehot(sel_id);
            mac_iv    <= 1'b1;
            state     <= S_ISSUE;
          end else if (state == S_HOLD) begin
            // Count idle cycles; the last allowed one releases the unit.
            if (hold_cnt == CW'(HOLD_TIMEOUT - 1)) begin
              state     <= S_IDLE;
              owner_vld <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mac_ov) begin
            s_out <= mac_s;
            done  <= onehot(owner_id);
            last  <= owner_id;
            if (lock_r) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end else begin
              state     <= S_IDLE;
              owner_vld <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed scenarios plus a randomized phase.
// A transaction-level model predicts acks, dones, ownership and results.
// A behavioural mul_acc (5-cycle latency) is attached to the mac_* ports.
module tb_mac_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned HT = 16;
  localparam int unsigned IW = 1;

  logic clk, rstn;
  logic [N-1:0] req, lock, clr, a_sb;
  logic [N*W-1:0] a, b;
  logic [N-1:0] ack, done;
  logic [W-1:0] s_out, mac_a, mac_b, mac_s;
  logic owner_vld, err, mac_iv, mac_clr, mac_a_sb, mac_ov;
  logic [IW-1:0] owner_id;

  mac_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .clr(clr), .a_sb(a_sb), .a(a), .b(b),
    .ack(ack), .done(done), .s_out(s_out), .owner_vld(owner_vld), .owner_id(owner_id),
    .err(err), .mac_iv(mac_iv), .mac_clr(mac_clr), .mac_a_sb(mac_a_sb), .mac_a(mac_a),
    .mac_b(mac_b), .mac_ov(mac_ov), .mac_s(mac_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mul_acc: the accumulator updates on iv, and the result appears 5 cycles later.
  logic [4:0]   pv;
  logic [W-1:0] ps [5];
  logic [W-1:0] acc_q, base_m, prod_m, nxt_m, inj_s;
  logic         inject;
  always_comb begin
    base_m = mac_clr ? '0 : acc_q;
    prod_m = W'(mac_a * mac_b);
    nxt_m  = mac_a_sb ? base_m + prod_m : base_m - prod_m;
  end
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv    <= '0;
      acc_q <= '0;
      ps    <= '{default: '0};
    end else begin
      pv    <= {pv[3:0], mac_iv};
      ps[0] <= nxt_m;
      for (int k = 1; k < 5; k++) ps[k] <= ps[k-1];
      if (mac_iv) acc_q <= nxt_m;
    end
  end
  assign mac_ov = pv[4] | inject;
  assign mac_s  = inject ? inj_s : ps[4];

  int n_pass, n_total;
  int n_ack [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  int m_busy, m_held, m_idle, m_last, m_cur;
  bit m_cur_lock;
  logic [W-1:0] m_acc;
  logic [N-1:0] e_ack, e_done;
  logic [W-1:0] e_s, e_ma, e_mb;
  logic e_ovld, e_err, e_iv, e_clr, e_asb;
  logic [IW-1:0] e_oid;

  task automatic model_reset();
    m_busy = 0; m_held = -1; m_idle = 0; m_last = N - 1; m_cur = 0; m_cur_lock = 0;
    m_acc = '0; e_ack = '0; e_done = '0; e_s = '0; e_ma = '0; e_mb = '0;
    e_ovld = 0; e_err = 0; e_iv = 0; e_clr = 0; e_asb = 0; e_oid = '0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    int idx;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (lst + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic accept(input int w);
    logic [W-1:0] av, bv, prod, base;
    av = a[w*W +: W];
    bv = b[w*W +: W];
    prod = W'(av * bv);
    base = clr[w] ? '0 : m_acc;
    m_acc = a_sb[w] ? base + prod : base - prod;
    e_ack = N'(1) << w;
    e_iv = 1; e_clr = clr[w]; e_ma = av; e_mb = bv; e_asb = a_sb[w];
    m_cur = w; m_cur_lock = lock[w]; m_busy = 6; m_held = -1;
    e_ovld = 1; e_oid = IW'(w);
  endtask

  // One clock edge of the transaction-level model; it is called at the posedge with the sampled inputs.
  task automatic model_edge();
    int w;
    e_ack = '0; e_done = '0; e_iv = 0; e_clr = 0;
    if (inject && m_busy == 0) e_err = 1;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        e_done = N'(1) << m_cur;
        e_s = m_acc;
        m_last = m_cur;
        if (m_cur_lock) begin m_held = m_cur; m_idle = 0; end
        else e_ovld = 0;
      end
    end else if (m_held >= 0) begin
      if (req[m_held]) accept(m_held);
      else begin
        m_idle++;
        if (m_idle == int'(HT)) begin m_held = -1; e_ovld = 0; end
      end
    end else begin
      w = rr_pick(req, m_last);
      if (w >= 0) accept(w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ack", 64'(ack), 64'(e_ack));
    check("done", 64'(done), 64'(e_done));
    check("s_out", 64'(s_out), 64'(e_s));
    check("owner_vld", 64'(owner_vld), 64'(e_ovld));
    check("owner_id", 64'(owner_id), 64'(e_oid));
    check("err", 64'(err), 64'(e_err));
    check("mac_iv", 64'(mac_iv), 64'(e_iv));
    check("mac_clr", 64'(mac_clr), 64'(e_clr));
    if (e_iv) begin
      check("mac_a", 64'(mac_a), 64'(e_ma));
      check("mac_b", 64'(mac_b), 64'(e_mb));
      check("mac_a_sb", 64'(mac_a_sb), 64'(e_asb));
    end
    for (int i = 0; i < int'(N); i++)
      if (ack[i]) begin n_ack[i]++; req[i] = 1'b0; end
  endtask

  task automatic drive_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic c, input logic s, input logic l);
    a[i*W +: W] = av; b[i*W +: W] = bv;
    clr[i] = c; a_sb[i] = s; lock[i] = l; req[i] = 1'b1;
  endtask

  task automatic drive_rand(input int i, input logic l);
    drive_op(i, W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), l);
  endtask

  // The reset is asserted in the middle of the low phase, and the outputs must clear at once.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_s_out", 64'(s_out), 64'(0));
    check("rst_owner_vld", 64'(owner_vld), 64'(0));
    check("rst_owner_id", 64'(owner_id), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_mac_iv", 64'(mac_iv), 64'(0));
    check("rst_mac_a", 64'(mac_a), 64'(0));
    check("rst_mac_b", 64'(mac_b), 64'(0));
    model_reset();
    req = '0; lock = '0; clr = '0; a_sb = '0; inject = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_ack(input int i, input int maxc, output int cyc);
    cyc = 0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (ack[i]) begin cyc = k; break; end
    end
    check("ack_within_bound", 64'(cyc != 0), 64'(1));
  endtask

  task automatic wait_done(input int i, input int maxc, output int cyc);
    cyc = 0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (done[i]) begin cyc = k; break; end
    end
    check("done_within_bound", 64'(cyc != 0), 64'(1));
  endtask

  initial begin
    int cyc, base0, cnt;
    int order [4];
    logic [W-1:0] s0;
    n_pass = 0; n_total = 0;
    for (int i = 0; i < int'(N); i++) n_ack[i] = 0;
    rstn = 1'b1; req = '0; lock = '0; clr = '0; a_sb = '0; a = '0; b = '0;
    inject = 1'b0; inj_s = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: single op
    drive_op(0, 16'd3, 16'd4, 1'b1, 1'b1, 1'b0);
    wait_ack(0, 4, cyc);
    check("t1_ack_lat", 64'(cyc), 64'(1));
    check("t1_mac_iv", 64'(mac_iv), 64'(1));
    wait_done(0, 10, cyc);
    check("t1_done_lat", 64'(cyc), 64'(6));
    check("t1_s_out", 64'(s_out), 64'(12));
    repeat (3) tick();

    // 2: contention, round-robin order 0,1,0,1
    do_reset();
    drive_rand(0, 1'b0);
    drive_rand(1, 1'b0);
    cnt = 0;
    for (int c = 0; c < 80 && cnt < 4; c++) begin
      tick();
      for (int i = 0; i < int'(N); i++)
        if (ack[i] && cnt < 4) begin
          order[cnt] = i;
          cnt++;
          if (cnt < 4) drive_rand(i, 1'b0);
        end
    end
    check("t2_count", 64'(cnt), 64'(4));
    check("t2_order0", 64'(order[0]), 64'(0));
    check("t2_order1", 64'(order[1]), 64'(1));
    check("t2_order2", 64'(order[2]), 64'(0));
    check("t2_order3", 64'(order[3]), 64'(1));
    repeat (20) tick();

    // 3: locked three-op sequence from req1 while req0 waits
    drive_op(1, 16'd2, 16'd5, 1'b1, 1'b1, 1'b1);
    wait_ack(1, 4, cyc);
    drive_op(0, 16'd7, 16'd7, 1'b1, 1'b1, 1'b0);
    base0 = n_ack[0];
    wait_done(1, 10, cyc);
    check("t3_s1", 64'(s_out), 64'(10));
    drive_op(1, 16'd3, 16'd3, 1'b0, 1'b1, 1'b1);
    wait_done(1, 12, cyc);
    check("t3_s2", 64'(s_out), 64'(19));
    drive_op(1, 16'd1, 16'd4, 1'b0, 1'b0, 1'b0);
    wait_done(1, 12, cyc);
    check("t3_s3", 64'(s_out), 64'(15));
    check("t3_req0_stalled", 64'(n_ack[0] - base0), 64'(0));
    wait_ack(0, 3, cyc);
    check("t3_req0_lat", 64'(cyc), 64'(1));
    repeat (10) tick();

    // 4a: the hold times out, and the waiting req0 is granted
    drive_op(1, 16'd1, 16'd1, 1'b1, 1'b1, 1'b1);
    wait_ack(1, 4, cyc);
    drive_op(0, 16'd2, 16'd2, 1'b1, 1'b1, 1'b0);
    wait_done(1, 10, cyc);
    for (int k = 1; k <= int'(HT); k++) begin
      tick();
      if (k == int'(HT) - 1) check("t4_still_owned", 64'(owner_vld), 64'(1));
    end
    check("t4_released", 64'(owner_vld), 64'(0));
    check("t4_no_ack_release", 64'(ack), 64'(0));
    tick();
    check("t4_ack0", 64'(ack), 64'(2'b01));
    wait_done(0, 10, cyc);
    repeat (2) tick();

    // 4b: req1 arriving in the timeout cycle keeps ownership
    drive_op(1, 16'd5, 16'd1, 1'b1, 1'b1, 1'b1);
    wait_ack(1, 4, cyc);
    drive_op(0, 16'd2, 16'd2, 1'b1, 1'b1, 1'b0);
    wait_done(1, 10, cyc);
    repeat (HT - 1) tick();
    drive_op(1, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
    tick();
    check("t4b_ack1", 64'(ack), 64'(2'b10));
    check("t4b_owned", 64'(owner_vld), 64'(1));
    wait_done(1, 10, cyc);
    check("t4b_s", 64'(s_out), 64'(6));
    wait_ack(0, 3, cyc);
    repeat (10) tick();

    // 5: reset while an op is in flight
    drive_op(0, 16'd9, 16'd9, 1'b1, 1'b1, 1'b0);
    wait_ack(0, 4, cyc);
    repeat (2) tick();
    do_reset();
    repeat (8) tick();
    drive_op(0, 16'd1, 16'd2, 1'b1, 1'b1, 1'b0);
    wait_ack(0, 3, cyc);
    check("t5_ack_after_rst", 64'(cyc), 64'(1));
    wait_done(0, 10, cyc);
    check("t5_s", 64'(s_out), 64'(2));
    repeat (2) tick();

    // 6: a stray mac_ov while idle sets the sticky err flag
    s0 = s_out;
    inj_s = 16'hbeef;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("t6_err", 64'(err), 64'(1));
    check("t6_s_kept", 64'(s_out), 64'(s0));
    check("t6_no_done", 64'(done), 64'(0));
    repeat (3) tick();
    check("t6_err_sticky", 64'(err), 64'(1));

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < int'(N); i++)
        if (!req[i] && $urandom_range(0, 99) < 12) drive_rand(i, 1'($urandom_range(0, 9) < 4));
      tick();
    end
    req = '0;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
